// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and baud timing helper for uart_rx_fifo (macro UART_RX_PARITY_EN adds PARITY state)
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

    typedef logic [7:0] byte_t;

    // Clocks per bit (half = 0) or clocks to mid start bit (half = 1).
    function automatic int baud_limit(input int clk_freq, input int baud_rate, input bit half);
        int lim;
        lim = clk_freq / baud_rate;
        return half ? lim / 2 : lim;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterised first-word-fall-through FIFO with extra-MSB pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign count    = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a FWFT byte FIFO; UART_RX_PARITY_EN adds even parity and parity_err
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        frame_err,
    output logic                        overrun,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int TIMER_LIMIT = baud_limit(CLK_FREQ, BAUD_RATE, 1'b0);
    localparam int HALF_LIMIT  = baud_limit(CLK_FREQ, BAUD_RATE, 1'b1);
    localparam int TW          = $clog2(TIMER_LIMIT);
    localparam logic [TW-1:0] FULL_T = TW'(TIMER_LIMIT - 1);
    localparam logic [TW-1:0] HALF_T = TW'(HALF_LIMIT - 1);

    logic      rx_m;
    logic      rx_s;
    rx_state_t state;
    logic [TW-1:0] timer;
    logic [2:0] bitcnt;
    byte_t     shift;
    logic      par_bad;
    logic      push_req;
    logic      pop;
    logic      fifo_full;
    logic      fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Push happens on the stop-sample edge itself, so the request is combinational.
    assign push_req  = (state == STOP) && (timer == FULL_T) && rx_s && !par_bad;
    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            par_bad   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= push_req && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    timer   <= '0;
                    par_bad <= 1'b0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (timer == HALF_T) begin
                        timer  <= '0;
                        bitcnt <= '0;
                        state  <= rx_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == FULL_T) begin
                        timer         <= '0;
                        shift[bitcnt] <= rx_s;
                        bitcnt        <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer == FULL_T) begin
                        timer   <= '0;
                        par_bad <= (rx_s != ^shift);
                        state   <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer == FULL_T) begin
                        timer     <= '0;
                        state     <= IDLE;
                        frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err <= rx_s && par_bad;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (shift),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (UART_RX_PARITY_EN adds the parity case)
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH   = 16;
    localparam int BIT_CYC = 10_000_000 / 115_200;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic [4:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip;
    int         pe_cnt;
    int         pe_exp;
`endif

    int   errors;
    int   checks;
    int   fe_cnt;
    int   fe_exp;
    int   ov_cnt;
    int   ov_exp;
    logic [7:0] q [$];

    uart_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
                else check("pop_data", {24'd0, out_data}, {24'd0, q.pop_front()});
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
        end
    end

    // Stop sample lands 46 clocks into the stop bit (2 sync + 1 idle + half bit).
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic raise,
                             input logic lat_chk, input int idle);
        logic [10:0] bits;
        logic        par_ok;
        int          nb;
`ifdef UART_RX_PARITY_EN
        nb     = 11;
        bits   = {stop_bit, (^d) ^ par_flip, d, 1'b0};
        par_ok = !par_flip;
`else
        nb     = 10;
        bits   = {1'b0, stop_bit, d, 1'b0};
        par_ok = 1'b1;
`endif
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            for (int c = 0; c < BIT_CYC; c++) begin
                if (i == nb - 1) begin
                    if (c == 45 && raise) out_ready = 1'b1;
                    if (c == 45 && lat_chk) check("valid_before_push", {31'd0, out_valid}, 32'd0);
                    if (c == 46) begin
                        if (lat_chk) check("valid_after_push", {31'd0, out_valid}, 32'd1);
                        if (!stop_bit) fe_exp++;
`ifdef UART_RX_PARITY_EN
                        else if (!par_ok) pe_exp++;
`endif
                        else if (q.size() == DEPTH) ov_exp++;
                        else if (par_ok) q.push_back(d);
                    end
                    if (c == 47 && lat_chk) check("valid_one_cycle", {31'd0, out_valid}, 32'd0);
                end
                step(1);
            end
        end
        rx = 1'b1;
        step(idle);
    endtask

    initial begin
        errors = 0; checks = 0;
        fe_cnt = 0; fe_exp = 0; ov_cnt = 0; ov_exp = 0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0; pe_cnt = 0; pe_exp = 0;
`endif
        rst = 1'b0; rx = 1'b1; out_ready = 1'b0;
        step(3);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        step(5);

        // single byte, latency
        out_ready = 1'b1;
        send_byte(8'hA5, 1'b1, 1'b0, 1'b1, 10);
        check("a5_frame_err", fe_cnt, 0);
        check("a5_drained", q.size(), 0);

        // three buffered bytes, then burst drain
        out_ready = 1'b0;
        send_byte(8'h00, 1'b1, 1'b0, 1'b0, 10);
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0, 10);
        send_byte(8'h3C, 1'b1, 1'b0, 1'b0, 10);
        check("three_count", {27'd0, fifo_count}, 32'd3);
        out_ready = 1'b1;
        step(3);
        check("three_drained_count", {27'd0, fifo_count}, 32'd0);
        check("three_drained_valid", {31'd0, out_valid}, 32'd0);

        // start-bit glitch
        rx = 1'b0;
        step(20);
        rx = 1'b1;
        step(100);
        check("glitch_idle", 32'(dut.state), 32'(IDLE));
        check("glitch_count", {27'd0, fifo_count}, 32'd0);
        check("glitch_frame_err", fe_cnt, fe_exp);

        // framing error, then recovery
        send_byte(8'h55, 1'b0, 1'b0, 1'b0, 20);
        check("fe_count", fe_cnt, 1);
        check("fe_fifo", {27'd0, fifo_count}, 32'd0);
        send_byte(8'h12, 1'b1, 1'b0, 1'b0, 10);
        check("after_fe_drained", q.size(), 0);

        // overrun on the 17th byte
        out_ready = 1'b0;
        for (int b = 0; b < 17; b++) send_byte(8'(b), 1'b1, 1'b0, 1'b0, 10);
        check("ovr_pulses", ov_cnt, 1);
        check("ovr_full_count", {27'd0, fifo_count}, 32'd16);
        out_ready = 1'b1;
        step(20);
        check("ovr_drained", q.size(), 0);

        // 17th push coincides with the first pop
        out_ready = 1'b0;
        for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b1, 1'b0, 1'b0, 10);
        send_byte(8'h10, 1'b1, 1'b1, 1'b0, 10);
        check("simul_no_overrun", ov_cnt, 1);
        step(20);
        check("simul_drained", q.size(), 0);
        check("simul_count", {27'd0, fifo_count}, 32'd0);

        // reset in the middle of a data field
        rx = 1'b0; step(BIT_CYC);
        rx = 1'b1; step(BIT_CYC);
        rx = 1'b0; step(BIT_CYC * 2);
        rst = 1'b0;
        step(3);
        check("midrst_count", {27'd0, fifo_count}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1; rx = 1'b1;
        step(20);
        send_byte(8'h7E, 1'b1, 1'b0, 1'b0, 10);
        check("after_rst_drained", q.size(), 0);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_byte(8'h01, 1'b1, 1'b0, 1'b0, 10);
        par_flip = 1'b0;
        check("parity_err_pulse", pe_cnt, pe_exp);
        check("parity_no_push", {27'd0, fifo_count}, 32'd0);
`endif

        step(50);
        check("final_frame_err", fe_cnt, fe_exp);
        check("final_overrun", ov_cnt, ov_exp);
        check("final_queue", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
